run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 22, run-mode tick divider width (tick period 2^DIV_W clk cycles).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port step, input, 1, debounced single-step button level.
REQ-005 SHALL have port run_tgl, input, 1, debounced run/stop button level.
REQ-006 SHALL have port bp_en, input, 1, breakpoint enable.
REQ-007 SHALL have port bp_addr, input, 16, breakpoint PC value.
REQ-008 SHALL have port pc, input, 16, current CPU program counter.
REQ-009 SHALL have port halted, input, 1, CPU reports IDLE state (program finished).
REQ-010 SHALL have port cpu_en, output, 1, one-cycle CPU clock-enable pulse.
REQ-011 SHALL have port mode, output, 2, current controller state.
REQ-012 SHALL have port bp_hit, output, 1, high while in BRK.
REQ-013 SHALL have port cycles, output, 16, count of cpu_en pulses issued.

Function
REQ-014 SHALL detect rising edges of step and run_tgl internally (registered previous level); a held level SHALL produce exactly one event.
REQ-015 SHALL implement states HALT=0, STEP=1, RUN=2, BRK=3, driven on mode.
REQ-016 HALT: run_tgl edge -> RUN; else step edge -> STEP; cpu_en=0.
REQ-017 STEP: SHALL last exactly one cycle, cpu_en=1 in that cycle, then -> HALT unconditionally.
REQ-018 RUN: divider SHALL clear to 0 on entry and increment every cycle, wrapping modulo 2^DIV_W; a tick occurs in the cycle divider equals all-ones.
REQ-019 RUN tick: if bp_en and pc==bp_addr and breakpoint not masked -> BRK with cpu_en=0; else cpu_en=1.
REQ-020 RUN: run_tgl edge -> HALT, taking priority over a same-cycle tick (no cpu_en that cycle).
REQ-021 RUN: halted=1 -> HALT at next edge, no cpu_en; halted SHALL be ignored in HALT, STEP, BRK.
REQ-022 BRK: bp_hit=1, cpu_en=0; run_tgl edge -> RUN; else step edge -> STEP.
REQ-023 Leaving BRK to RUN SHALL mask the breakpoint compare for the first tick only, so execution proceeds past the breakpoint instruction.
REQ-024 Simultaneous step and run_tgl edges: run_tgl SHALL win in every state.
REQ-025 cycles SHALL increment by 1 on each cpu_en pulse and saturate at 16'hFFFF.
REQ-026 Outputs cpu_en, mode, bp_hit SHALL be registered (no combinational path from inputs).

Reset
REQ-027 On reset low: mode=HALT, cpu_en=0, bp_hit=0, cycles=0, divider=0, mask=0, edge-detect history=1 (a button held through reset SHALL not fire on release of reset).
REQ-028 Reset asserted mid-RUN or mid-STEP SHALL abort immediately; no cpu_en pulse after reset deasserts until a new edge event.

Structure
REQ-029 State encodings HALT/STEP/RUN/BRK SHALL be defined as macros in the shared defines header alongside the CPU state encodings.
REQ-030 One sub-module edge_det (level in, one-cycle rising-edge pulse out, async active-low reset) SHALL be instantiated twice.
REQ-031 Divider, FSM and counter SHALL reside in run_ctrl; target 120-250 RTL lines.

Verification (DIV_W=2)
REQ-032 Reset, one step edge -> mode 0->1->0, exactly one cpu_en pulse, cycles=1.
REQ-033 run_tgl edge, bp_en=0, hold 20 cycles -> cpu_en every 4th cycle, first at 4 cycles after entering RUN; second run_tgl edge -> HALT, pulses stop.
REQ-034 RUN, bp_en=1, bp_addr=16'h0005, pc reaches 5 -> mode=3, bp_hit=1, no pulse at that tick; run_tgl edge -> next tick pulses despite pc=5.
REQ-035 step and run_tgl rise same cycle in HALT -> mode=2, no STEP pulse.
REQ-036 RUN with halted=1 -> mode=0 next cycle; preload cycles near 16'hFFFF via long run -> stays 16'hFFFF.
REQ-037 reset low mid-RUN with step held high -> all outputs zero; release reset with step still high -> no STEP.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/step controller and the CPU it supervises.
// The macros are the single source of truth for the state values.
`ifndef RUN_CTRL_DEFS_SVH
`define RUN_CTRL_DEFS_SVH
`define RC_HALT   2'd0
`define RC_STEP   2'd1
`define RC_RUN    2'd2
`define RC_BRK    2'd3
`define CPU_IDLE  2'd0
`define CPU_FETCH 2'd1
`define CPU_DEC   2'd2
`define CPU_EXEC  2'd3
`endif

package run_ctrl_pkg;

  localparam int unsigned PcW  = 16;
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StHalt = `RC_HALT,
    StStep = `RC_STEP,
    StRun  = `RC_RUN,
    StBrk  = `RC_BRK
  } rc_state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector; history resets high so a level held through reset never fires.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign pulse = level & ~prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Run/step/breakpoint controller producing single-cycle CPU clock enables.
module run_ctrl #(
  parameter int unsigned DIV_W = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        run_tgl,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic [15:0] pc,
  input  logic        halted,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic        bp_hit,
  output logic [15:0] cycles
);

  import run_ctrl_pkg::*;

  logic            step_evt;
  logic            run_evt;
  rc_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic            mask_q, mask_d;
  logic            cpu_en_q, cpu_en_d;
  logic            bp_hit_q;
  logic [CntW-1:0] cycles_q;
  logic            tick;
  logic            bp_match;

  edge_det u_step_edge (
    .clk   (clk),
    .reset (reset),
    .level (step),
    .pulse (step_evt)
  );

  edge_det u_run_edge (
    .clk   (clk),
    .reset (reset),
    .level (run_tgl),
    .pulse (run_evt)
  );

  assign tick     = (state_q == StRun) && (&div_q);
  assign bp_match = bp_en && (pc == bp_addr) && !mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StHalt;
      div_q    <= '0;
      mask_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      bp_hit_q <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mask_q   <= mask_d;
      cpu_en_q <= cpu_en_d;
      bp_hit_q <= (state_d == StBrk);
      cycles_q <= cpu_en_d ? sat_inc(cycles_q) : cycles_q;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mask_d  = mask_q;
    unique case (state_q)
      StHalt, StBrk: begin
        if (run_evt) begin
          state_d = StRun;
          div_d   = '0;
          // Resuming from a breakpoint must step past the breakpoint instruction.
          mask_d  = (state_q == StBrk);
        end else if (step_evt) begin
          state_d = StStep;
        end
      end
      StStep: state_d = StHalt;
      StRun: begin
        div_d = div_q + 1'b1;
        if (run_evt || halted) begin
          state_d = StHalt;
        end else if (tick) begin
          mask_d = 1'b0;
          if (bp_match) begin
            state_d = StBrk;
          end
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    cpu_en_d = 1'b0;
    unique case (state_q)
      StHalt, StBrk: cpu_en_d = !run_evt && step_evt;
      StRun:         cpu_en_d = !run_evt && !halted && tick && !bp_match;
      default:       cpu_en_d = 1'b0;
    endcase
  end

  assign cpu_en = cpu_en_q;
  assign mode   = state_q;
  assign bp_hit = bp_hit_q;
  assign cycles = cycles_q;

endmodule
